// File: rtl/digit_scan_display.sv
// Captures ring digits on each STEP edge and scans the last four onto a
// 4-digit common-anode 7-seg display.
//   CLK, RST (sync, active-high), STEP (async level), DIGIT[7:0]
//   SEG[6:0] {g..a} active-low, AN[3:0] active-low, STEP_CNT[7:0]
module digit_scan_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       STEP,
  input  logic [7:0] DIGIT,
  output logic [6:0] SEG,
  output logic [3:0] AN,
  output logic [7:0] STEP_CNT
);

  localparam logic [15:0] TERM = 16'(SCAN_DIV - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            sync3_q, sync3_d;
  logic [3:0][7:0] slot_q, slot_d;
  logic [3:0]      vld_q, vld_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [15:0]     pre_q, pre_d;
  logic [1:0]      idx_q, idx_d;
  logic            cap;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
    endcase
    return g;
  endfunction

  always_comb begin
    sync1_d = STEP;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    slot_d  = slot_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q + 16'd1;
    idx_d   = idx_q;

    cap = sync2_q & ~sync3_q;
    if (cap) begin
      slot_d = {slot_q[2:0], DIGIT};
      vld_d  = {vld_q[2:0], 1'b1};
      cnt_d  = cnt_q + 8'd1;
    end

    if (pre_q == TERM) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      slot_q  <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      slot_q  <= slot_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
    end
  end

  // Display path decodes registered state only, so it is glitch-free
  // with respect to the asynchronous STEP input.
  always_comb begin
    logic [7:0] sel;
    sel = slot_q[idx_q];
    SEG = 7'b1111111;
    if (vld_q[idx_q]) begin
      if (sel[7:4] != 4'h0) SEG = 7'b0111111;
      else                  SEG = hex_glyph(sel[3:0]);
    end
  end

  assign AN       = ~(4'b0001 << idx_q);
  assign STEP_CNT = cnt_q;

endmodule
